// File: rtl/quadrilatero_pkg.sv
// ---------------------------------------------------------------------------
// quadrilatero_pkg
//   Types shared by the matrix unit: systolic-array control word, the
//   dispatcher issue-queue entry, the in-flight tracking entry and the
//   dispatcher state encoding.
// ---------------------------------------------------------------------------
package quadrilatero_pkg;

  localparam int SA_N_REGS = 8;
  localparam int SA_REG_W  = $clog2(SA_N_REGS);
  localparam int SA_ID_W   = xif_pkg::X_ID_WIDTH;

  // SIMD lane mode and floating-point enable forwarded to the array.
  typedef struct packed {
    logic       fp_en;
    logic [1:0] simd_mode;
  } sa_ctrl_t;

  // One buffered matrix-multiply request; acc_reg is also the destination.
  typedef struct packed {
    logic [SA_REG_W-1:0] data_reg;
    logic [SA_REG_W-1:0] weight_reg;
    logic [SA_REG_W-1:0] acc_reg;
    sa_ctrl_t            ctrl;
    logic [SA_ID_W-1:0]  id;
  } sa_disp_entry_t;

  // What must be remembered about an instruction while it is in the array.
  typedef struct packed {
    logic [SA_ID_W-1:0]  id;
    logic [SA_REG_W-1:0] acc_reg;
  } sa_inflight_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sa_disp_state_e;

endpackage

// File: rtl/xif_pkg.sv
// ---------------------------------------------------------------------------
// xif_pkg
//   Shared constants of the coprocessor-interface boundary. Only the
//   instruction ID width is needed by the systolic-array dispatcher.
// ---------------------------------------------------------------------------
package xif_pkg;

  localparam int X_ID_WIDTH = 4;

endpackage

// File: rtl/quadrilatero_sa_issue_queue.sv
// ---------------------------------------------------------------------------
// quadrilatero_sa_issue_queue
//   In-order circular FIFO of an arbitrary packed entry type. DEPTH need not
//   be a power of two (the pointers wrap explicitly), so the same block also
//   serves as the in-flight tracker sized to MAX_INFLIGHT.
//
// Ports
//   clk_i, rst_i  clock, synchronous active-high reset
//   push_i        write push_data_i at the tail (ignored when full)
//   push_data_i   entry to write
//   pop_i         drop the head entry (ignored when empty)
//   head_o        current head entry (stale contents when empty)
//   full_o        count == DEPTH
//   count_o       number of valid entries
// ---------------------------------------------------------------------------
module quadrilatero_sa_issue_queue
  import quadrilatero_pkg::*;
#(
  parameter type         entry_t = sa_disp_entry_t,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/quadrilatero_sa_dispatcher.sv
// ---------------------------------------------------------------------------
// quadrilatero_sa_dispatcher
//   Issue controller between matrix-instruction decode and the systolic
//   array. Requests are buffered in order, held back while any operand
//   register is the accumulator of an instruction still in the array, started
//   with a one-cycle sa_start_o, and their completions are handed on as an
//   in-order retire stream.
//
// Ports
//   req_*            request handshake and operands (acc is the destination)
//   sa_ready_i       array can accept a start
//   sa_start_o       start pulse; sa_*_o always show the queue head (0 if empty)
//   sa_finished_*    completion level/ID from the array, acknowledged by
//                    a one-cycle sa_finished_ack_o
//   retire_*         valid/ready stream of completed IDs
//   drain_i          stop issuing until the array pipeline is empty
//   drain_done_o     one-cycle pulse when the drain has finished
//   inflight_cnt_o   issued but not yet completed instructions
//   error_o          sticky: completion out of order or with nothing in flight
// ---------------------------------------------------------------------------
module quadrilatero_sa_dispatcher
  import quadrilatero_pkg::*;
#(
  parameter int unsigned N_REGS       = SA_N_REGS,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned ID_WIDTH     = xif_pkg::X_ID_WIDTH,
  localparam int unsigned REG_W       = $clog2(N_REGS),
  localparam int unsigned IF_CNT_W    = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [REG_W-1:0]    req_data_reg_i,
  input  logic [REG_W-1:0]    req_weight_reg_i,
  input  logic [REG_W-1:0]    req_acc_reg_i,
  input  sa_ctrl_t            req_ctrl_i,
  input  logic [ID_WIDTH-1:0] req_id_i,
  input  logic                sa_ready_i,
  output logic                sa_start_o,
  output logic [REG_W-1:0]    sa_data_reg_o,
  output logic [REG_W-1:0]    sa_weight_reg_o,
  output logic [REG_W-1:0]    sa_acc_reg_o,
  output sa_ctrl_t            sa_ctrl_o,
  output logic [ID_WIDTH-1:0] sa_id_o,
  input  logic                sa_finished_i,
  input  logic [ID_WIDTH-1:0] sa_finished_id_i,
  output logic                sa_finished_ack_o,
  output logic                retire_valid_o,
  output logic [ID_WIDTH-1:0] retire_id_o,
  input  logic                retire_ready_i,
  input  logic                drain_i,
  output logic                drain_done_o,
  output logic [IF_CNT_W-1:0] inflight_cnt_o,
  output logic                error_o
);

  localparam int unsigned Q_CNT_W = $clog2(DEPTH + 1);

  sa_disp_state_e      state_q, state_d;
  logic [N_REGS-1:0]   busy_q, busy_d;
  logic                retire_valid_q;
  logic [ID_WIDTH-1:0] retire_id_q;
  logic                ack_q;
  logic                error_q;

  sa_disp_entry_t      req_entry;
  sa_disp_entry_t      q_head;
  sa_disp_entry_t      head_entry;
  logic                q_full;
  logic [Q_CNT_W-1:0]  q_count;
  logic                q_empty;
  logic                req_push;

  sa_inflight_t        if_push_data;
  sa_inflight_t        if_head;
  logic                if_full;
  logic [IF_CNT_W-1:0] if_count;
  logic                if_empty;

  logic                issue;
  logic                fin_window;
  logic                capture;
  logic                err_set;
  logic                retire_hs;
  logic                drain_done;

  assign req_entry.data_reg   = req_data_reg_i;
  assign req_entry.weight_reg = req_weight_reg_i;
  assign req_entry.acc_reg    = req_acc_reg_i;
  assign req_entry.ctrl       = req_ctrl_i;
  assign req_entry.id         = req_id_i;

  // Ready comes only from the registered fill level, so a pop at full does
  // not open a slot within the same cycle.
  assign req_ready_o = ~q_full;
  assign req_push    = req_valid_i & req_ready_o;

  quadrilatero_sa_issue_queue #(
    .entry_t (sa_disp_entry_t),
    .DEPTH   (DEPTH)
  ) u_issue_q (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (req_push),
    .push_data_i (req_entry),
    .pop_i       (issue),
    .head_o      (q_head),
    .full_o      (q_full),
    .count_o     (q_count)
  );

  assign q_empty    = (q_count == '0);
  assign head_entry = q_empty ? '0 : q_head;

  assign if_push_data.id      = head_entry.id;
  assign if_push_data.acc_reg = head_entry.acc_reg;

  // Remembers issue order so completions can be checked and the right
  // accumulator released.
  quadrilatero_sa_issue_queue #(
    .entry_t (sa_inflight_t),
    .DEPTH   (MAX_INFLIGHT)
  ) u_inflight_q (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (issue),
    .push_data_i (if_push_data),
    .pop_i       (capture),
    .head_o      (if_head),
    .full_o      (if_full),
    .count_o     (if_count)
  );

  assign if_empty = (if_count == '0);

  // Hazard check uses the registered busy mask only; a register released by
  // a completion becomes issuable the cycle after the acknowledge.
  assign issue = ~q_empty & (state_q == RUN) & sa_ready_i & ~if_full
               & ~busy_q[head_entry.data_reg]
               & ~busy_q[head_entry.weight_reg]
               & ~busy_q[head_entry.acc_reg];

  // The array holds sa_finished_i until it sees the ack; ack_q masks the
  // cycle in which the level is still high after being accepted.
  assign fin_window = sa_finished_i & ~retire_valid_q & ~ack_q;
  assign capture    = fin_window & ~if_empty;
  assign err_set    = fin_window & (if_empty | (sa_finished_id_i != if_head.id));
  assign retire_hs  = retire_valid_q & retire_ready_i;
  assign drain_done = (state_q == DRAIN) & if_empty & ~retire_valid_q;

  assign sa_start_o        = issue;
  assign sa_data_reg_o     = head_entry.data_reg;
  assign sa_weight_reg_o   = head_entry.weight_reg;
  assign sa_acc_reg_o      = head_entry.acc_reg;
  assign sa_ctrl_o         = head_entry.ctrl;
  assign sa_id_o           = head_entry.id;
  assign sa_finished_ack_o = capture;
  assign retire_valid_o    = retire_valid_q;
  assign retire_id_o       = retire_id_q;
  assign drain_done_o      = drain_done;
  assign inflight_cnt_o    = if_count;
  assign error_o           = error_q;

  // Leaving IDLE also looks at a push in progress so the first start can
  // happen the cycle after acceptance; likewise RUN stays put while a push
  // is arriving into an empty machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (drain_i)                      state_d = DRAIN;
        else if (~q_empty | req_push)     state_d = RUN;
      end
      RUN: begin
        if (drain_i)                                state_d = DRAIN;
        else if (q_empty & ~req_push & if_empty)    state_d = IDLE;
      end
      DRAIN: begin
        if (drain_done)                   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Release happens before set; hazard checking guarantees the two never
  // target the same register in one cycle.
  always_comb begin
    busy_d = busy_q;
    if (capture) busy_d[if_head.acc_reg]    = 1'b0;
    if (issue)   busy_d[head_entry.acc_reg] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      busy_q         <= '0;
      retire_valid_q <= 1'b0;
      retire_id_q    <= '0;
      ack_q          <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ack_q   <= capture;
      error_q <= error_q | err_set;
      if (capture) begin
        retire_valid_q <= 1'b1;
        retire_id_q    <= sa_finished_id_i;
      end else if (retire_hs) begin
        retire_valid_q <= 1'b0;
        retire_id_q    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_quadrilatero_sa_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_quadrilatero_sa_dispatcher
//   Directed bench for the systolic-array dispatcher with a queue-based
//   reference model checked on every falling edge, plus literal checks at
//   the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_quadrilatero_sa_dispatcher;
  import quadrilatero_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_data_reg = '0, req_weight_reg = '0, req_acc_reg = '0;
  sa_ctrl_t   req_ctrl = '0;
  logic [3:0] req_id = '0;
  logic       sa_ready = 1'b1;
  logic       sa_start;
  logic [2:0] sa_data_reg, sa_weight_reg, sa_acc_reg;
  sa_ctrl_t   sa_ctrl;
  logic [3:0] sa_id;
  logic       sa_finished = 1'b0;
  logic [3:0] sa_finished_id = '0;
  logic       sa_finished_ack;
  logic       retire_valid;
  logic [3:0] retire_id;
  logic       retire_ready = 1'b1;
  logic       drain = 1'b0;
  logic       drain_done;
  logic [1:0] inflight_cnt;
  logic       error;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  quadrilatero_sa_dispatcher dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_data_reg_i    (req_data_reg),
    .req_weight_reg_i  (req_weight_reg),
    .req_acc_reg_i     (req_acc_reg),
    .req_ctrl_i        (req_ctrl),
    .req_id_i          (req_id),
    .sa_ready_i        (sa_ready),
    .sa_start_o        (sa_start),
    .sa_data_reg_o     (sa_data_reg),
    .sa_weight_reg_o   (sa_weight_reg),
    .sa_acc_reg_o      (sa_acc_reg),
    .sa_ctrl_o         (sa_ctrl),
    .sa_id_o           (sa_id),
    .sa_finished_i     (sa_finished),
    .sa_finished_id_i  (sa_finished_id),
    .sa_finished_ack_o (sa_finished_ack),
    .retire_valid_o    (retire_valid),
    .retire_id_o       (retire_id),
    .retire_ready_i    (retire_ready),
    .drain_i           (drain),
    .drain_done_o      (drain_done),
    .inflight_cnt_o    (inflight_cnt),
    .error_o           (error)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue, the in-flight list and the retire slot as
  // plain SV queues; mode 0 = idle, 1 = run, 2 = drain.
  sa_disp_entry_t m_q[$];
  logic [3:0]     m_if_id[$];
  logic [2:0]     m_if_acc[$];
  bit             m_busy[8];
  int             m_mode;
  bit             m_slot_v, m_ack_q, m_err, m_on = 0;
  logic [3:0]     m_slot_id;

  sa_disp_entry_t e_head, e_new;
  bit e_ready, e_push, e_issue, e_win, e_cap, e_err_set, e_dd;
  int e_cnt, e_next;

  always @(negedge clk) begin
    if (m_on) begin
      e_cnt     = m_q.size();
      e_ready   = (e_cnt != 4);
      e_push    = req_valid && e_ready;
      e_head    = (e_cnt > 0) ? m_q[0] : '0;
      e_issue   = (e_cnt > 0) && (m_mode == 1) && sa_ready && (m_if_id.size() < 3)
                  && !m_busy[e_head.data_reg] && !m_busy[e_head.weight_reg]
                  && !m_busy[e_head.acc_reg];
      e_win     = sa_finished && !m_slot_v && !m_ack_q;
      e_cap     = e_win && (m_if_id.size() > 0);
      e_err_set = e_win && ((m_if_id.size() == 0) || (m_if_id[0] != sa_finished_id));
      e_dd      = (m_mode == 2) && (m_if_id.size() == 0) && !m_slot_v;

      check_output("req_ready", req_ready, e_ready);
      check_output("sa_start", sa_start, e_issue);
      check_output("sa_data_reg", sa_data_reg, e_head.data_reg);
      check_output("sa_weight_reg", sa_weight_reg, e_head.weight_reg);
      check_output("sa_acc_reg", sa_acc_reg, e_head.acc_reg);
      check_output("sa_ctrl", sa_ctrl, e_head.ctrl);
      check_output("sa_id", sa_id, e_head.id);
      check_output("ack", sa_finished_ack, e_cap);
      check_output("retire_valid", retire_valid, m_slot_v);
      check_output("retire_id", retire_id, m_slot_v ? m_slot_id : 4'd0);
      check_output("drain_done", drain_done, e_dd);
      check_output("inflight_cnt", inflight_cnt, m_if_id.size());
      check_output("error", error, m_err);
    end

    if (rst_i) begin
      m_q.delete(); m_if_id.delete(); m_if_acc.delete();
      foreach (m_busy[i]) m_busy[i] = 0;
      m_mode = 0; m_slot_v = 0; m_slot_id = '0; m_ack_q = 0; m_err = 0;
      m_on = 1;
    end else if (m_on) begin
      e_next = m_mode;
      if (m_mode == 0) begin
        if (drain) e_next = 2;
        else if (e_cnt > 0 || e_push) e_next = 1;
      end else if (m_mode == 1) begin
        if (drain) e_next = 2;
        else if (e_cnt == 0 && !e_push && m_if_id.size() == 0) e_next = 0;
      end else if (e_dd) e_next = 0;

      if (e_cap) begin
        m_busy[m_if_acc[0]] = 0;
        void'(m_if_id.pop_front());
        void'(m_if_acc.pop_front());
        m_slot_v = 1; m_slot_id = sa_finished_id;
      end else if (m_slot_v && retire_ready) begin
        m_slot_v = 0; m_slot_id = '0;
      end
      if (e_issue) begin
        m_busy[e_head.acc_reg] = 1;
        m_if_id.push_back(e_head.id);
        m_if_acc.push_back(e_head.acc_reg);
        void'(m_q.pop_front());
      end
      if (e_push) begin
        e_new.data_reg = req_data_reg; e_new.weight_reg = req_weight_reg;
        e_new.acc_reg = req_acc_reg; e_new.ctrl = req_ctrl; e_new.id = req_id;
        m_q.push_back(e_new);
      end
      m_ack_q = e_cap;
      m_err   = m_err | e_err_set;
      m_mode  = e_next;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic [2:0] d, w, a, input logic [3:0] id);
    req_data_reg = d; req_weight_reg = w; req_acc_reg = a; req_id = id;
    req_ctrl = sa_ctrl_t'(id[2:0]);
  endtask

  // Presents one request for one cycle (caller ensures the queue has room).
  task automatic apply_stimulus(input logic [2:0] d, w, a, input logic [3:0] id);
    set_req(d, w, a, id);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Array reports completion; the ack must appear in the same cycle.
  task automatic complete(input logic [3:0] id);
    sa_finished = 1'b1; sa_finished_id = id;
    #1 check_output("complete_ack", sa_finished_ack, 1);
    tick();
    sa_finished = 1'b0;
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // 1: reset values, first issue latency, busy tracking
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    check_output("rst_req_ready", req_ready, 1);
    check_output("rst_sa_start", sa_start, 0);
    check_output("rst_inflight", inflight_cnt, 0);
    check_output("rst_error", error, 0);
    check_output("rst_retire_valid", retire_valid, 0);
    check_output("rst_drain_done", drain_done, 0);
    check_output("rst_ack", sa_finished_ack, 0);
    apply_stimulus(3'd0, 3'd1, 3'd2, 4'd1);
    check_output("t1_start", sa_start, 1);
    check_output("t1_acc", sa_acc_reg, 2);
    check_output("t1_id", sa_id, 1);
    tick();
    check_output("t1_inflight", inflight_cnt, 1);
    check_output("t1_model_busy2", m_busy[2], 1);
    check_output("t1_no_restart", sa_start, 0);
    complete(4'd1);
    check_output("t1_inflight_done", inflight_cnt, 0);

    // 2: RAW hazard on the accumulator of an in-flight instruction
    apply_stimulus(3'd0, 3'd1, 3'd2, 4'd1);
    apply_stimulus(3'd2, 3'd3, 3'd4, 4'd2);
    check_output("t2_blocked", sa_start, 0);
    check_output("t2_head", sa_id, 2);
    tick(); tick();
    check_output("t2_still_blocked", sa_start, 0);
    sa_finished = 1'b1; sa_finished_id = 4'd1;
    #1 check_output("t2_ack", sa_finished_ack, 1);
    check_output("t2_no_start_on_ack", sa_start, 0);
    tick();
    sa_finished = 1'b0;
    check_output("t2_start_after_ack", sa_start, 1);
    check_output("t2_start_id", sa_id, 2);
    tick();
    complete(4'd2);

    // 3: in-flight limit
    for (int k = 0; k < 5; k++) begin
      set_req(3'(k + 1), 3'(k + 1), 3'(k + 1), 4'(k + 3));
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    tick(); tick();
    check_output("t3_limit_start", sa_start, 0);
    check_output("t3_limit_inflight", inflight_cnt, 3);
    check_output("t3_limit_head", sa_id, 6);
    sa_finished = 1'b1; sa_finished_id = 4'd3;
    #1 check_output("t3_ack", sa_finished_ack, 1);
    check_output("t3_no_start_same", sa_start, 0);
    tick();
    sa_finished = 1'b0;
    check_output("t3_fourth_start", sa_start, 1);
    check_output("t3_fourth_id", sa_id, 6);
    tick(); tick();
    for (int k = 4; k < 8; k++) complete(4'(k));
    check_output("t3_empty", inflight_cnt, 0);

    // 4: full queue, push+pop at full rejects the push
    sa_ready = 1'b0;
    for (int k = 0; k < 4; k++) apply_stimulus(3'(k + 4), 3'(k + 4), 3'(k + 4), 4'(k + 8));
    check_output("t4_full", req_ready, 0);
    set_req(3'd1, 3'd1, 3'd1, 4'd12);
    req_valid = 1'b1; sa_ready = 1'b1;
    #1 check_output("t4_full_pop_ready", req_ready, 0);
    check_output("t4_full_pop_start", sa_start, 1);
    tick();
    req_valid = 1'b0; sa_ready = 1'b0;
    check_output("t4_after_pop_ready", req_ready, 1);
    check_output("t4_after_pop_head", sa_id, 9);
    sa_ready = 1'b1;
    tick(); tick(); tick();
    for (int k = 8; k < 12; k++) complete(4'(k));
    check_output("t4_empty", inflight_cnt, 0);

    // 5: retire back-pressure with the completion level held high
    apply_stimulus(3'd1, 3'd1, 3'd1, 4'd5);
    tick();
    retire_ready = 1'b0;
    sa_finished = 1'b1; sa_finished_id = 4'd5;
    #1 check_output("t5_ack", sa_finished_ack, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_output("t5_rv_hold", retire_valid, 1);
      check_output("t5_rid_hold", retire_id, 5);
      check_output("t5_single_ack", sa_finished_ack, 0);
      tick();
    end
    sa_finished = 1'b0; retire_ready = 1'b1;
    tick(); tick();
    check_output("t5_rv_clear", retire_valid, 0);
    check_output("t5_no_error", error, 0);

    // 6: drain with two in flight, completions out of order
    apply_stimulus(3'd1, 3'd1, 3'd1, 4'd1);
    apply_stimulus(3'd2, 3'd2, 3'd2, 4'd2);
    tick();
    check_output("t6_two_inflight", inflight_cnt, 2);
    drain = 1'b1; tick(); drain = 1'b0;
    set_req(3'd3, 3'd3, 3'd3, 4'd3);
    req_valid = 1'b1;
    #1 check_output("t6_drain_accepts", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check_output("t6_drain_no_start", sa_start, 0);
    check_output("t6_drain_head", sa_id, 3);
    sa_finished = 1'b1; sa_finished_id = 4'd2;
    #1 check_output("t6_ack_swapped", sa_finished_ack, 1);
    tick(); sa_finished = 1'b0; tick(); tick();
    check_output("t6_error_set", error, 1);
    check_output("t6_not_done_yet", drain_done, 0);
    sa_finished = 1'b1; sa_finished_id = 4'd1;
    #1 check_output("t6_ack_second", sa_finished_ack, 1);
    tick();
    sa_finished = 1'b0;
    check_output("t6_done_wait_hs", drain_done, 0);
    tick();
    check_output("t6_drain_done", drain_done, 1);
    check_output("t6_inflight_zero", inflight_cnt, 0);
    tick();
    check_output("t6_done_single", drain_done, 0);
    check_output("t6_idle_no_start", sa_start, 0);
    tick();
    check_output("t6_resume_start", sa_start, 1);
    check_output("t6_resume_id", sa_id, 3);
    tick();
    complete(4'd3);
    check_output("t6_error_sticky", error, 1);

    // 7: drain with nothing in flight
    tick(); tick();
    drain = 1'b1; tick(); drain = 1'b0;
    check_output("t7_quick_done", drain_done, 1);
    tick();
    check_output("t7_done_once", drain_done, 0);

    // Reset clears the sticky error
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    check_output("rst_clears_error", error, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
